// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU: data width, operation indices and
// the quotient returned on a divide by zero.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    localparam logic [DATA_W-1:0] DIV_BY_ZERO_VAL = 8'hFF;

endpackage

// File: rtl/alu_if.sv
// Operand, strobe and result signals of the ALU, bundled for the datapath.
interface alu_if;
    import alu_pkg::*;

    logic              ISUMn;
    logic              ISUBn;
    logic              IMULn;
    logic              IDIVn;
    logic              ISHLn;
    logic              ISHRn;
    logic              An;
    logic              Bn;
    logic [DATA_W-1:0] DinA;
    logic [DATA_W-1:0] DinB;
    logic [DATA_W-1:0] Din;
    logic [DATA_W-1:0] Dout;

    modport master (
        output ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn,
        output An, Bn, DinA, DinB, Din,
        input  Dout
    );

    modport slave (
        input  ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn,
        input  An, Bn, DinA, DinB, Din,
        output Dout
    );

endinterface

// File: rtl/alu_div8.sv
// Combinational 8-bit restoring divider: one shift/compare/subtract stage per
// quotient bit, MSB first.
module alu_div8
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient
);

    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] q;

    always_comb begin
        rem = '0;
        q   = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            rem = {rem[DATA_W-1:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem  = rem - {1'b0, divisor};
                q[i] = 1'b1;
            end
        end
        quotient = (divisor == '0) ? DIV_BY_ZERO_VAL : q;
    end

endmodule

// File: rtl/alu.sv
// 8-bit ALU: operand muxes, strobe priority decode, result mux and the Dout
// register. All arithmetic is unsigned and truncated to 8 bits.
module alu
    import alu_pkg::*;
(
    input  logic CLK,
    input  logic CLRn,
    alu_if.slave bus
);

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;
    logic [2:0]        op_sel;
    logic              op_vld;

    assign a = bus.An ? bus.DinA : bus.Din;
    assign b = bus.Bn ? bus.DinB : bus.Din;

    alu_div8 u_div (
        .dividend (a),
        .divisor  (b),
        .quotient (quot)
    );

    // Several strobes low at once resolve SUM > SUB > MUL > DIV > SHL > SHR.
    always_comb begin
        op_vld = 1'b1;
        op_sel = OP_SUM;
        if      (!bus.ISUMn) op_sel = OP_SUM;
        else if (!bus.ISUBn) op_sel = OP_SUB;
        else if (!bus.IMULn) op_sel = OP_MUL;
        else if (!bus.IDIVn) op_sel = OP_DIV;
        else if (!bus.ISHLn) op_sel = OP_SHL;
        else if (!bus.ISHRn) op_sel = OP_SHR;
        else                 op_vld = 1'b0;
    end

    always_comb begin
        result = '0;
        case (op_sel)
            OP_SUM:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV:  result = quot;
            OP_SHL:  result = (b > 8'd7) ? '0 : (a << b[2:0]);
            OP_SHR:  result = (b > 8'd7) ? '0 : (a >> b[2:0]);
            default: result = '0;
        endcase
        dout_d = op_vld ? result : dout_q;
    end

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) dout_q <= '0;
        else       dout_q <= dout_d;
    end

    assign bus.Dout = dout_q;

endmodule

// File: tb/tb_alu.sv
// Bench for the ALU: directed cases followed by randomized operations checked
// against an arithmetic reference model.
module tb_alu;

    logic CLK  = 1'b0;
    logic CLRn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_dout = 8'h00;

    // Strobe vector, bit k low selects: 0 SUM, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR
    logic [5:0] sn = 6'h3F;

    alu_if bus ();

    alu dut (
        .CLK  (CLK),
        .CLRn (CLRn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.ISUMn = sn[0];
    assign bus.ISUBn = sn[1];
    assign bus.IMULn = sn[2];
    assign bus.IDIVn = sn[3];
    assign bus.ISHLn = sn[4];
    assign bus.ISHRn = sn[5];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%02h want=%02h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ref_alu(input logic [5:0] s, input logic an, input logic bn,
                                           input logic [7:0] dina, input logic [7:0] dinb,
                                           input logic [7:0] din, input logic [7:0] prev);
        int av, bv, r;
        av = an ? int'(dina) : int'(din);
        bv = bn ? int'(dinb) : int'(din);
        if      (!s[0]) r = (av + bv) % 256;
        else if (!s[1]) r = (av - bv + 256) % 256;
        else if (!s[2]) r = (av * bv) % 256;
        else if (!s[3]) r = (bv == 0) ? 255 : av / bv;
        else if (!s[4]) r = (bv > 7) ? 0 : (av * (1 << bv)) % 256;
        else if (!s[5]) r = (bv > 7) ? 0 : av / (1 << bv);
        else            r = int'(prev);
        return r[7:0];
    endfunction

    function automatic logic [5:0] only(input int k);
        logic [5:0] one;
        one = 6'b000001 << k;
        return ~one;
    endfunction

    task automatic drive(input logic [5:0] s, input logic an, input logic bn,
                         input logic [7:0] dina, input logic [7:0] dinb, input logic [7:0] din);
        sn       = s;
        bus.An   = an;
        bus.Bn   = bn;
        bus.DinA = dina;
        bus.DinB = dinb;
        bus.Din  = din;
    endtask

    // Clock one edge and compare against a literal expected value.
    task automatic tick_lit(input string tag, input logic [7:0] want);
        @(posedge CLK);
        #1;
        exp_dout = want;
        chk(tag, bus.Dout, want);
    endtask

    // Clock one edge and compare against the reference model.
    task automatic tick_ref(input string tag);
        logic [7:0] want;
        want = ref_alu(sn, bus.An, bus.Bn, bus.DinA, bus.DinB, bus.Din, exp_dout);
        @(posedge CLK);
        #1;
        exp_dout = want;
        chk(tag, bus.Dout, want);
    endtask

    initial begin
        drive(only(0), 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);

        // Reset held with an active SUM strobe
        #3;
        chk("rst_async", bus.Dout, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            chk("rst_hold", bus.Dout, 8'h00);
        end
        #3;
        CLRn = 1'b1;
        #1;
        chk("rst_release", bus.Dout, 8'h00);
        tick_lit("rst_first_sum", 8'h33);

        // Operand select
        drive(only(0), 1'b0, 1'b1, 8'hAA, 8'h00, 8'h06);
        tick_lit("sel_a_din", 8'h06);
        drive(only(0), 1'b1, 1'b0, 8'h07, 8'h55, 8'h02);
        tick_lit("sel_b_din", 8'h09);
        drive(only(0), 1'b0, 1'b0, 8'h07, 8'h55, 8'h21);
        tick_lit("sel_both_din", 8'h42);

        // Subtract
        drive(only(1), 1'b1, 1'b0, 8'h07, 8'h00, 8'h05);
        tick_lit("sub_7_5", 8'h02);
        drive(only(1), 1'b1, 1'b0, 8'h07, 8'h00, 8'h00);
        tick_lit("sub_7_0", 8'h07);
        drive(only(1), 1'b1, 1'b0, 8'h00, 8'h00, 8'h01);
        tick_lit("sub_borrow", 8'hFF);

        // Multiply / divide
        drive(only(2), 1'b1, 1'b1, 8'h20, 8'h09, 8'h00);
        tick_lit("mul_trunc", 8'h20);
        drive(only(3), 1'b1, 1'b1, 8'h07, 8'h03, 8'h00);
        tick_lit("div_7_3", 8'h02);
        drive(only(3), 1'b1, 1'b1, 8'h07, 8'h00, 8'h00);
        tick_lit("div_zero", 8'hFF);
        drive(only(3), 1'b1, 1'b1, 8'hFF, 8'h01, 8'h00);
        tick_lit("div_ff_1", 8'hFF);

        // Shifts
        drive(only(5), 1'b1, 1'b1, 8'h07, 8'h02, 8'h00);
        tick_lit("shr_7_2", 8'h01);
        drive(only(4), 1'b1, 1'b1, 8'h07, 8'h02, 8'h00);
        tick_lit("shl_7_2", 8'h1C);
        drive(only(4), 1'b1, 1'b1, 8'h07, 8'h08, 8'h00);
        tick_lit("shl_over", 8'h00);
        drive(only(5), 1'b1, 1'b1, 8'h80, 8'h07, 8'h00);
        tick_lit("shr_7", 8'h01);

        // Priority and hold
        drive(only(0) & only(1), 1'b1, 1'b1, 8'h07, 8'h02, 8'h00);
        tick_lit("prio_sum_sub", 8'h09);
        drive(only(2) & only(5), 1'b1, 1'b1, 8'h05, 8'h03, 8'h00);
        tick_lit("prio_mul_shr", 8'h0F);
        for (int i = 0; i < 4; i++) begin
            drive(6'h3F, 1'b1, 1'b1, 8'(i * 37), 8'(i * 11 + 1), 8'(i * 5));
            tick_lit("hold", 8'h0F);
        end

        // Reset in the middle of a pending operation
        drive(only(0), 1'b1, 1'b1, 8'h10, 8'h20, 8'h00);
        @(negedge CLK);
        CLRn = 1'b0;
        #1;
        exp_dout = 8'h00;
        chk("rst_mid", bus.Dout, 8'h00);
        @(posedge CLK);
        #1;
        chk("rst_mid_edge", bus.Dout, 8'h00);
        CLRn = 1'b1;
        tick_lit("rst_mid_after", 8'h30);

        // Randomized operations
        for (int n = 0; n < 400; n++) begin
            logic [5:0] s;
            logic [7:0] bv;
            case ($urandom_range(0, 9))
                0:       s = 6'($urandom);
                1:       s = 6'h3F;
                default: s = only(int'($urandom_range(0, 5)));
            endcase
            bv = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            drive(s, 1'($urandom), 1'($urandom), 8'($urandom), bv, 8'($urandom));
            tick_ref("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
